// File: rtl/tx_word_scheduler_if.sv
// CPU register bus and transmit stream bundle for tx_word_scheduler.
// The slave side belongs to the scheduler; the master side belongs to the CPU/transmitter model.
interface tx_word_scheduler_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              irq;

    modport slave (
        input  address, chipselect, write_n, writedata, tx_ready,
        output readdata, tx_data, tx_valid, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, tx_ready,
        input  readdata, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/tx_word_scheduler.sv
// Avalon-MM TX controller: CPU-filled word FIFO drained onto a valid/ready stream
// with a programmable idle gap between accepted words and a drain-complete interrupt.
module tx_word_scheduler #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int GAP_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    tx_word_scheduler_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic                    enable_q, irq_en_q, overflow_q;
    logic [GAP_W-1:0]        gap_q, cnt_q;
    logic [DATA_W-1:0]       tx_data_q;

    logic wr_en, push_req, push, ctrl_wr, status_wr, gap_wr, flush;
    logic full, empty, handshake, can_load;
    logic load, cnt_load, tx_valid;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign push_req  = wr_en && (bus.address == 2'd0);
    assign ctrl_wr   = wr_en && (bus.address == 2'd1);
    assign status_wr = wr_en && (bus.address == 2'd2);
    assign gap_wr    = wr_en && (bus.address == 2'd3);
    assign flush     = ctrl_wr & bus.writedata[1];

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    // Fullness is judged on the pre-edge level, so a pop in the same cycle does not rescue the word.
    assign push      = push_req & ~full;
    assign handshake = (state_q == ST_SEND) & bus.tx_ready;
    assign can_load  = enable_q & ~empty & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last gap cycle doubles as the IDLE decision so exactly GAP low cycles separate words.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (can_load) state_d = ST_SEND;
            ST_SEND: begin
                if (handshake) begin
                    if (gap_q != '0)   state_d = ST_GAP;
                    else if (can_load) state_d = ST_SEND;
                    else               state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_W'(1)) state_d = can_load ? ST_SEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        cnt_load = 1'b0;
        tx_valid = 1'b0;
        case (state_q)
            ST_IDLE: load = can_load;
            ST_SEND: begin
                tx_valid = 1'b1;
                if (handshake) begin
                    if (gap_q != '0) cnt_load = 1'b1;
                    else             load     = can_load;
                end
            end
            ST_GAP: if (cnt_q == GAP_W'(1)) load = can_load;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (load) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            case ({push, load})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= bus.writedata[0];
                irq_en_q <= bus.writedata[2];
            end
            if (gap_wr) gap_q <= bus.writedata[GAP_W-1:0];
            if (push_req && full)                    overflow_q <= 1'b1;
            else if (status_wr && bus.writedata[4]) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            tx_data_q <= '0;
        end else begin
            if (cnt_load)                cnt_q <= gap_q;
            else if (state_q == ST_GAP)  cnt_q <= cnt_q - GAP_W'(1);
            if (load) tx_data_q <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd1: begin
                bus.readdata[0] = enable_q;
                bus.readdata[2] = irq_en_q;
            end
            2'd2: begin
                bus.readdata[8 +: LVL_W] = level_q;
                bus.readdata[4]          = overflow_q;
                bus.readdata[3]          = (state_q != ST_IDLE);
                bus.readdata[1]          = full;
                bus.readdata[0]          = empty;
            end
            2'd3:    bus.readdata[GAP_W-1:0] = gap_q;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid;
    assign bus.irq      = irq_en_q & empty & (state_q == ST_IDLE);
endmodule

// File: tb/tb_tx_word_scheduler.sv
// Directed bench for tx_word_scheduler: register access, streaming order, backpressure,
// inter-word gap, overflow, flush, interrupt and asynchronous reset.
module tb_tx_word_scheduler;
    localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_GAP = 2'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] rv;

    tx_word_scheduler_if #(.DATA_W(32)) bus ();

    tx_word_scheduler #(.DATA_W(32), .DEPTH_LOG2(3), .GAP_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("[TB] write addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
        $display("[TB] read addr=%0d data=%h", a, d);
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.tx_ready   = 1'b0;

        // Reset state
        #3;
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_data", bus.tx_data, 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        rd(A_STAT, rv); check("rst_status", rv, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step(1);

        // Basic back-to-back streaming with GAP=0
        bus.tx_ready = 1'b1;
        wr(A_GAP, 32'd0);
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'hA5A5_0001);
        check("b_valid_lat0", 32'(bus.tx_valid), 32'd0);
        wr(A_DATA, 32'hA5A5_0002);
        check("b_valid_w1", 32'(bus.tx_valid), 32'd1);
        check("b_data_w1", bus.tx_data, 32'hA5A5_0001);
        step(1);
        check("b_valid_w2", 32'(bus.tx_valid), 32'd1);
        check("b_data_w2", bus.tx_data, 32'hA5A5_0002);
        step(1);
        check("b_valid_end", 32'(bus.tx_valid), 32'd0);
        rd(A_STAT, rv); check("b_status_end", rv, 32'h0000_0001);

        // Backpressure then a 3-cycle gap
        bus.tx_ready = 1'b0;
        wr(A_GAP, 32'd3);
        rd(A_GAP, rv); check("g_gap_reg", rv, 32'd3);
        wr(A_DATA, 32'hB000_0001);
        wr(A_DATA, 32'hB000_0002);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("g_hold_v%0d", i), 32'(bus.tx_valid), 32'd1);
            check($sformatf("g_hold_d%0d", i), bus.tx_data, 32'hB000_0001);
            if (i < 4) step(1);
        end
        bus.tx_ready = 1'b1;
        step(1);
        rd(A_STAT, rv); check("g_status_gap", rv, 32'h0000_0108);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("g_low%0d", i), 32'(bus.tx_valid), 32'd0);
            step(1);
        end
        check("g_valid_w2", 32'(bus.tx_valid), 32'd1);
        check("g_data_w2", bus.tx_data, 32'hB000_0002);
        step(4);
        rd(A_STAT, rv); check("g_status_end", rv, 32'h0000_0001);
        wr(A_GAP, 32'd0);

        // Overflow: ninth word dropped
        wr(A_CTRL, 32'h0);
        for (int i = 1; i <= 9; i++) wr(A_DATA, 32'h0000_0400 + 32'(i));
        rd(A_STAT, rv); check("o_status_full", rv, 32'h0000_0812);
        wr(A_STAT, 32'h10);
        rd(A_STAT, rv); check("o_status_clr", rv, 32'h0000_0802);
        wr(A_CTRL, 32'h1);
        check("o_valid_pre", 32'(bus.tx_valid), 32'd0);
        step(1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("o_valid%0d", k), 32'(bus.tx_valid), 32'd1);
            check($sformatf("o_data%0d", k), bus.tx_data, 32'h0000_0400 + 32'(k));
            step(1);
        end
        check("o_valid_end", 32'(bus.tx_valid), 32'd0);
        rd(A_STAT, rv); check("o_status_end", rv, 32'h0000_0001);

        // Flush with enable cleared while a word is stalled
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(A_DATA, 32'hC000_0000 + 32'(i));
        rd(A_STAT, rv); check("f_status_q", rv, 32'h0000_0308);
        wr(A_CTRL, 32'h2);
        check("f_valid_hold", 32'(bus.tx_valid), 32'd1);
        check("f_data_hold", bus.tx_data, 32'hC000_0001);
        rd(A_STAT, rv); check("f_status_flushed", rv, 32'h0000_0009);
        bus.tx_ready = 1'b1;
        step(1);
        check("f_valid_end", 32'(bus.tx_valid), 32'd0);
        rd(A_STAT, rv); check("f_status_end", rv, 32'h0000_0001);
        rd(A_CTRL, rv); check("f_ctrl", rv, 32'h0000_0000);
        step(2);
        check("f_valid_idle", 32'(bus.tx_valid), 32'd0);

        // Interrupt on drain completion
        bus.tx_ready = 1'b0;
        wr(A_CTRL, 32'h5);
        rd(A_CTRL, rv); check("i_ctrl", rv, 32'h0000_0005);
        check("i_irq_idle", 32'(bus.irq), 32'd1);
        wr(A_DATA, 32'hD000_0001);
        check("i_irq_queued", 32'(bus.irq), 32'd0);
        wr(A_DATA, 32'hD000_0002);
        check("i_irq_send1", 32'(bus.irq), 32'd0);
        bus.tx_ready = 1'b1;
        step(1);
        check("i_data_w2", bus.tx_data, 32'hD000_0002);
        check("i_irq_send2", 32'(bus.irq), 32'd0);
        step(1);
        check("i_irq_done", 32'(bus.irq), 32'd1);

        // Asynchronous reset while a word is in flight
        bus.tx_ready = 1'b0;
        wr(A_DATA, 32'hF000_0001);
        step(1);
        check("r_valid_pre", 32'(bus.tx_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("r_valid", 32'(bus.tx_valid), 32'd0);
        check("r_data", bus.tx_data, 32'd0);
        check("r_irq", 32'(bus.irq), 32'd0);
        rd(A_STAT, rv); check("r_status", rv, 32'h0000_0001);
        #2 reset_n = 1'b1;
        step(2);
        check("r_valid_after", 32'(bus.tx_valid), 32'd0);
        rd(A_CTRL, rv); check("r_ctrl", rv, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
